// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that shares a 2:1 mux datapath between two requesters
// and presents the selected data downstream with a valid/ready handshake.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             last0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    input  logic             last1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     state;
    logic       prio;
    logic [3:0] burst_cnt;

    logic cur_req, cur_last, granted;
    logic transfer, rel_last, rel_burst, rel_abandon, rel;
    logic take0, take1, drop;

    assign granted   = gnt0 | gnt1;
    assign cur_req   = gnt1 ? req1 : req0;
    assign cur_last  = gnt1 ? last1 : last0;

    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign result    = sel ? d1 : d0;
    assign transfer  = out_valid & out_ready;

    assign rel_last    = transfer & cur_last;
    assign rel_burst   = transfer & (burst_cnt == LAST_CNT);
    assign rel_abandon = granted & ~cur_req;
    assign rel         = rel_last | rel_burst | rel_abandon;

    // The other requester always wins a release; a burst-limit release
    // re-grants the same owner only when nobody else is waiting.
    always_comb begin
        take0 = 1'b0;
        take1 = 1'b0;
        drop  = 1'b0;
        case (state)
            IDLE: begin
                take0 = req0 & (~req1 | ~prio);
                take1 = req1 & ~take0;
            end
            GRANT0: begin
                if (rel) begin
                    if (req1)                              take1 = 1'b1;
                    else if (req0 & rel_burst & ~rel_last) take0 = 1'b1;
                    else                                   drop  = 1'b1;
                end
            end
            GRANT1: begin
                if (rel) begin
                    if (req0)                              take0 = 1'b1;
                    else if (req1 & rel_burst & ~rel_last) take1 = 1'b1;
                    else                                   drop  = 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            sel       <= 1'b0;
            prio      <= 1'b0;
            burst_cnt <= 4'd0;
        end else begin
            if (rel)
                prio <= (state == GRANT0);

            if (take0) begin
                state     <= GRANT0;
                gnt0      <= 1'b1;
                gnt1      <= 1'b0;
                sel       <= 1'b0;
                burst_cnt <= 4'd0;
            end else if (take1) begin
                state     <= GRANT1;
                gnt0      <= 1'b0;
                gnt1      <= 1'b1;
                sel       <= 1'b1;
                burst_cnt <= 4'd0;
            end else if (drop) begin
                state     <= IDLE;
                gnt0      <= 1'b0;
                gnt1      <= 1'b0;
                burst_cnt <= 4'd0;
            end else if (transfer) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Round-robin controller that shares the 2:1 transmission-gate mux datapath between two requesters. It arbitrates the requests, drives the mux select, and presents the selected data to a single downstream consumer with a valid/ready handshake. Bursts are bounded per grant. The exported sel output drives the mux s input directly. The internal result path mirrors the mux function, so the block can be used standalone.

Parameters:
WIDTH, 1, data width of d0/d1/result (the mux datapath is 1 bit)
MAX_BURST, 4, max transfers per grant before forced hand-over; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 wants the datapath; held high while it has data
d0  input  WIDTH  requester 0 data (mux d0)
last0  input  1  marks the final beat of requester 0's burst; qualified by transfer
req1  input  1  requester 1 request
d1  input  WIDTH  requester 1 data (mux d1)
last1  input  1  final beat of requester 1's burst
out_ready  input  1  downstream accepts data
gnt0  output  1  requester 0 owns the datapath (registered)
gnt1  output  1  requester 1 owns the datapath (registered)
sel  output  1  mux select: 0 = d0, 1 = d1 (registered)
out_valid  output  1  result is valid this cycle
result  output  WIDTH  sel ? d1 : d0 (combinational from registered sel)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt0=gnt1=0, sel=0, out_valid=0, prio pointer=0 (requester 0 wins first tie), burst_cnt=0. Assertion mid-burst aborts the burst immediately, with no completion beat.
- States: IDLE, GRANT0, GRANT1. gnt0=1 only in GRANT0, and gnt1=1 only in GRANT1. The two grants are never high together.
- IDLE:
  - Only reqX high -> GRANTX next edge.
  - Both high -> grant the requester indicated by the prio pointer.
  - Neither high -> stay in IDLE; sel holds its last value.
- Entry into GRANTX: sel=X, burst_cnt=0. Request-to-grant latency is exactly 1 cycle.
- out_valid = (GRANT0 & req0) | (GRANT1 & req1). It is combinational from registered state and the live request.
- Transfer = out_valid & out_ready. burst_cnt increments on each transfer. With out_ready=0 the block holds: no count, no release.
- Release of GRANTX at the next edge when any of the following holds:
  - (a) transfer with lastX=1;
  - (b) transfer with burst_cnt == MAX_BURST-1;
  - (c) reqX=0 while granted (abandon; no transfer that cycle).
- On release, prio pointer is set to the other requester (~X). Next state:
  - GRANT(~X) if req(~X)=1. Direct switch, no idle bubble; sel flips at that edge.
  - else GRANTX if reqX=1 and the release reason was (b). Re-grant with burst_cnt=0.
  - else IDLE.
- MAX_BURST=1: every transfer releases, giving strict alternation under contention.
- burst_cnt width is 4 bits. It never wraps, because release occurs at MAX_BURST-1.
- last ignored when not a transfer cycle. last asserted while not granted has no effect.
- Simultaneous release and other request: the other requester always wins (fairness). A starved requester waits at most MAX_BURST transfers plus 1 cycle.
- sel changes only on grant-change edges. result is glitch-free relative to clk.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then req0=req1=0 -> gnt0=gnt1=0, sel=0, out_valid=0; rst_n low mid-GRANT1 -> gnt1 and sel drop to 0 asynchronously, before the next clk edge.
- Single requester: req0=1, d0=1, out_ready=1, last0 on beat 2 -> gnt0=1 one cycle after req0, 2 transfers with result=1, then IDLE (gnt0=0).
- Contention tie: req0=req1=1 from IDLE after reset, no last, MAX_BURST=4 -> GRANT0 for 4 transfers, then GRANT1 with no bubble and sel 0->1 on the same edge; pointer alternates thereafter.
- Backpressure: GRANT1, out_ready=0 for 3 cycles -> out_valid=1, burst_cnt stays 0, gnt1 held; out_ready=1 then counts resume.
- Abandon: GRANT0, req0 drops with req1=1 -> next edge GRANT1, no transfer counted for requester 0.
- Burst limit re-grant: req1 only, continuous, MAX_BURST=4, no last1 -> release after 4 transfers, immediate re-grant to 1, and burst_cnt restarts at 0.
